// File: rtl/rr_arbiter_8ch_32b.sv
// Round-robin arbiter sharing one 32-bit valid/ready output among 8 requesters.
// Optional feature macro ARB_BURST_EN: hold a grant for up to MAX_BURST back-to-back transfers.

module mux_8to1_32b (
  input  logic [255:0] data,
  input  logic [2:0]   sel,
  output logic [31:0]  y
);
  assign y = data[{sel, 5'd0} +: 32];
endmodule

module rr_arbiter_8ch_32b #(
  parameter int CNT_W     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       req_valid,
  input  logic [255:0]     req_data,
  output logic [7:0]       req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [2:0]       sel,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] next_ptr;
  logic       xfer;
  logic       burst_more;

  // First valid requester scanning p, p+1, ... with 3-bit wraparound.
  function automatic logic [2:0] rr_pick(input logic [7:0] v, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && v[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  mux_8to1_32b u_mux (
    .data (req_data),
    .sel  (sel),
    .y    (out_data)
  );

  assign out_valid = (state == GRANT) && req_valid[sel];
  assign req_ready = ((state == GRANT) && out_ready) ? (8'd1 << sel) : 8'd0;
  assign xfer      = out_valid && out_ready;
  assign next_ptr  = sel + 3'd1;

`ifdef ARB_BURST_EN
  localparam int BURST_W = $clog2(MAX_BURST) + 1;

  logic [BURST_W-1:0] burst_cnt;

  assign burst_more = (32'(burst_cnt) + 32'd1) < 32'(MAX_BURST);
`else
  logic unused_max_burst;

  assign burst_more       = 1'b0;
  assign unused_max_burst = (MAX_BURST > 0);
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      sel      <= '0;
      ptr      <= '0;
      xfer_cnt <= '0;
`ifdef ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      if (xfer) xfer_cnt <= xfer_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (|req_valid) begin
            sel   <= rr_pick(req_valid, ptr);
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req_valid[sel]) begin
            // Granted requester withdrew: give up the grant, pointer untouched.
            state <= IDLE;
`ifdef ARB_BURST_EN
            burst_cnt <= '0;
`endif
          end else if (out_ready) begin
            if (burst_more) begin
`ifdef ARB_BURST_EN
              burst_cnt <= burst_cnt + BURST_W'(1);
`endif
            end else begin
              // Re-arbitrate with the just-served requester at lowest priority.
              ptr <= next_ptr;
              sel <= rr_pick(req_valid, next_ptr);
`ifdef ARB_BURST_EN
              burst_cnt <= '0;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
